// File: rtl/instr_encoder_loader_pkg.sv
// Shared RV32I field constants and control codes for the encode/decode paths.
// Keeping them in one place stops the loader's encoder drifting from the control-unit decoders.
package instr_encoder_loader_pkg;

    localparam logic [2:0] CLS_R      = 3'd0;
    localparam logic [2:0] CLS_I      = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef struct packed {
        logic       legal;
        logic [2:0] funct3;
    } alu_f3_t;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} ld_state_e;

    function automatic alu_f3_t alu_funct3(input logic [2:0] alu);
        alu_f3_t r;
        r = '{legal: 1'b0, funct3: 3'b000};
        case (alu)
            ALU_ADD, ALU_SUB: r = '{legal: 1'b1, funct3: F3_ADD_SUB};
            ALU_AND:          r = '{legal: 1'b1, funct3: F3_AND};
            ALU_OR:           r = '{legal: 1'b1, funct3: F3_OR};
            ALU_SLT:          r = '{legal: 1'b1, funct3: F3_SLT};
            default:          r = '{legal: 1'b0, funct3: 3'b000};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request bus (valid/ready) into the loader and write port out to instruction memory.
interface instr_encoder_loader_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_class;
    logic [2:0]        req_alu;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [12:0]       req_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output req_valid, req_class, req_alu, req_rd, req_rs1, req_rs2, req_imm,
        input  req_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_class, req_alu, req_rd, req_rs1, req_rs2, req_imm,
        output req_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader_encode.sv
// Combinational RV32I encoder: field request -> {machine word, illegal}; zero latency, no flow control.
module rv_instr_encode
    import instr_encoder_loader_pkg::*;
(
    input  logic [2:0]  cls,
    input  logic [2:0]  alu,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        illegal
);
    alu_f3_t f3r;

    always_comb begin
        f3r     = alu_funct3(alu);
        word    = '0;
        illegal = 1'b0;
        case (cls)
            CLS_R: begin
                word    = {(alu == ALU_SUB) ? F7_SUB : F7_BASE, rs2, rs1, f3r.funct3, rd, OP_R};
                illegal = !f3r.legal;
            end
            CLS_I: begin
                // No subtract-immediate in RV32I; negative addi covers it.
                word    = {imm[11:0], rs1, f3r.funct3, rd, OP_I};
                illegal = !f3r.legal || (alu == ALU_SUB);
            end
            CLS_LOAD: begin
                word = {imm[11:0], rs1, F3_WORD, rd, OP_LOAD};
            end
            CLS_STORE: begin
                word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_STORE};
            end
            CLS_BRANCH: begin
                word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
                illegal = imm[0];
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// Streams encoded RV32I words into instruction memory from word 0; one-cycle accept-to-write latency,
// 1 word/cycle; req_ready drops outside LOAD, on start, and when accepted words would exceed DEPTH.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter  int DEPTH  = 64,
    parameter  int ADDR_W = 32,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                finish,
    instr_encoder_loader_if.slave bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CNT_W-1:0]    count
);
    localparam int CW1 = CNT_W + 1;

    ld_state_e         state, state_nxt;
    logic              pipe_vld;
    logic [31:0]       pipe_word;
    logic [CNT_W-1:0]  idx;
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              in_load, room, accept, write, overflow;

    rv_instr_encode u_enc (
        .cls     (bus.req_class),
        .alu     (bus.req_alu),
        .rd      (bus.req_rd),
        .rs1     (bus.req_rs1),
        .rs2     (bus.req_rs2),
        .imm     (bus.req_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // The word sitting in the pipe already owns a slot, so room counts it too.
    assign in_load  = (state == ST_LOAD) && !start && !rst;
    assign room     = (CW1'(idx) + CW1'(pipe_vld)) < CW1'(DEPTH);
    assign accept   = bus.req_valid && bus.req_ready;
    assign overflow = in_load && bus.req_valid && !room;
    assign write    = pipe_vld && !start && !rst;

    assign bus.req_ready = in_load && room;
    assign bus.mem_we    = write;
    assign bus.mem_addr  = ADDR_W'({idx, 2'b00});
    assign bus.mem_wdata = pipe_word;
    assign busy          = (state == ST_LOAD) || (state == ST_DRAIN) || pipe_vld;
    assign done          = (state == ST_DONE);
    assign count         = idx;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_LOAD;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_IDLE;
                ST_LOAD:  if (finish) state_nxt = ST_DRAIN;
                ST_DRAIN: if (!pipe_vld) state_nxt = ST_DONE;
                ST_DONE:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld  <= 1'b0;
            pipe_word <= '0;
            idx       <= '0;
            err       <= 1'b0;
        end else if (start) begin
            pipe_vld <= 1'b0;
            idx      <= '0;
            err      <= 1'b0;
        end else begin
            pipe_vld <= accept && !enc_illegal;
            if (accept && !enc_illegal) pipe_word <= enc_word;
            if (write) idx <= idx + CNT_W'(1);
            if ((accept && enc_illegal) || overflow) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: encoding table streamed back-to-back, then session/overflow/reset corner sequences.
module tb_instr_encoder_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, finish, busy, done, err;
    logic [6:0] count;
    logic       s_start, s_finish, s_busy, s_done, s_err;
    logic [2:0] s_count;

    instr_encoder_loader_if #(.ADDR_W(32)) bus ();
    instr_encoder_loader_if #(.ADDR_W(32)) sbus ();

    instr_encoder_loader #(.DEPTH(64), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish), .bus(bus),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    instr_encoder_loader #(.DEPTH(4), .ADDR_W(32)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .finish(s_finish), .bus(sbus),
        .busy(s_busy), .done(s_done), .err(s_err), .count(s_count)
    );

    typedef struct {
        logic [2:0]  cls;
        logic [2:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
        bit          bad;
        logic [31:0] word;
    } vec_t;

    vec_t vt[14];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [2:0] c, input logic [2:0] a, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                                input bit bad, input logic [31:0] w);
        vec_t v;
        v.cls = c; v.alu = a; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.bad = bad; v.word = w;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.req_valid = 1'b1;
        bus.req_class = v.cls;
        bus.req_alu   = v.alu;
        bus.req_rd    = v.rd;
        bus.req_rs1   = v.rs1;
        bus.req_rs2   = v.rs2;
        bus.req_imm   = v.imm;
    endtask

    task automatic wait_done(input string nm, input logic [31:0] exp_cnt);
        bit got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk({nm, "_done_seen"}, 32'(got), 32'd1);
        chk({nm, "_count"}, 32'(count), exp_cnt);
        tick();
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
        chk({nm, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_ready"}, 32'(bus.req_ready), 32'd0);
        chk({nm, "_we"}, 32'(bus.mem_we), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_err"}, 32'(err), 32'd0);
        chk({nm, "_addr"}, bus.mem_addr, 32'd0);
        chk({nm, "_wdata"}, bus.mem_wdata, 32'd0);
        chk({nm, "_count"}, 32'(count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_idx;
        bit exp_err;
        int nw;

        vt[0]  = mk(3'd1, 3'b000, 5'd1,  5'd0,  5'd0,  13'd5,     1'b0, 32'h00500093); // addi x1,x0,5
        vt[1]  = mk(3'd0, 3'b000, 5'd3,  5'd1,  5'd2,  13'd0,     1'b0, 32'h002081B3); // add x3,x1,x2
        vt[2]  = mk(3'd0, 3'b001, 5'd3,  5'd1,  5'd2,  13'd0,     1'b0, 32'h402081B3); // sub x3,x1,x2
        vt[3]  = mk(3'd2, 3'b000, 5'd5,  5'd2,  5'd0,  13'd8,     1'b0, 32'h00812283); // lw x5,8(x2)
        vt[4]  = mk(3'd3, 3'b000, 5'd0,  5'd2,  5'd5,  13'd12,    1'b0, 32'h00512623); // sw x5,12(x2)
        vt[5]  = mk(3'd4, 3'b000, 5'd0,  5'd1,  5'd2,  13'h1FF8,  1'b0, 32'hFE208CE3); // beq x1,x2,-8
        vt[6]  = mk(3'd4, 3'b000, 5'd0,  5'd1,  5'd2,  13'h1FF9,  1'b1, 32'h0);        // odd branch offset
        vt[7]  = mk(3'd0, 3'b010, 5'd4,  5'd5,  5'd6,  13'd0,     1'b0, 32'h0062F233); // and x4,x5,x6
        vt[8]  = mk(3'd0, 3'b011, 5'd7,  5'd8,  5'd9,  13'd0,     1'b0, 32'h009463B3); // or x7,x8,x9
        vt[9]  = mk(3'd0, 3'b101, 5'd10, 5'd11, 5'd12, 13'd0,     1'b0, 32'h00C5A533); // slt x10,x11,x12
        vt[10] = mk(3'd1, 3'b001, 5'd1,  5'd2,  5'd0,  13'd3,     1'b1, 32'h0);        // I-type sub
        vt[11] = mk(3'd5, 3'b000, 5'd1,  5'd2,  5'd3,  13'd0,     1'b1, 32'h0);        // bad class
        vt[12] = mk(3'd0, 3'b100, 5'd1,  5'd2,  5'd3,  13'd0,     1'b1, 32'h0);        // bad alu
        vt[13] = mk(3'd1, 3'b101, 5'd1,  5'd2,  5'd0,  13'h1FFF,  1'b0, 32'hFFF12093); // slti x1,x2,-1

        rst = 1'b1; start = 1'b0; finish = 1'b0; s_start = 1'b0; s_finish = 1'b0;
        bus.req_valid = 1'b0; bus.req_class = '0; bus.req_alu = '0; bus.req_rd = '0;
        bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_imm = '0;
        sbus.req_valid = 1'b0; sbus.req_class = 3'd1; sbus.req_alu = '0; sbus.req_rd = 5'd1;
        sbus.req_rs1 = '0; sbus.req_rs2 = '0; sbus.req_imm = 13'd5;
        tick(); tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();

        // Requests outside a session are not taken.
        drive(vt[0]);
        #1 chk("idle_ready", 32'(bus.req_ready), 32'd0);
        tick();
        chk("idle_we", 32'(bus.mem_we), 32'd0);
        bus.req_valid = 1'b0;

        // Encoding table, streamed back-to-back in one session.
        start = 1'b1; tick(); start = 1'b0;
        chk("session_busy", 32'(busy), 32'd1);
        exp_idx = 0;
        exp_err = 1'b0;
        for (int i = 0; i < 14; i++) begin
            drive(vt[i]);
            #1 chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'd1);
            tick();
            if (!vt[i].bad) begin
                chk($sformatf("v%0d_we", i), 32'(bus.mem_we), 32'd1);
                chk($sformatf("v%0d_addr", i), bus.mem_addr, 32'(exp_idx * 4));
                chk($sformatf("v%0d_wdata", i), bus.mem_wdata, vt[i].word);
            end else begin
                chk($sformatf("v%0d_we", i), 32'(bus.mem_we), 32'd0);
            end
            exp_err = exp_err | vt[i].bad;
            chk($sformatf("v%0d_err", i), 32'(err), 32'(exp_err));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(exp_idx));
            if (!vt[i].bad) exp_idx++;
        end
        bus.req_valid = 1'b0;
        finish = 1'b1; tick(); finish = 1'b0;
        wait_done("table", 32'(exp_idx));

        // finish together with an accept still writes that word.
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_err_clear", 32'(err), 32'd0);
        drive(vt[0]); finish = 1'b1;
        tick();
        finish = 1'b0; bus.req_valid = 1'b0;
        chk("fin_acc_we", 32'(bus.mem_we), 32'd1);
        chk("fin_acc_wdata", bus.mem_wdata, 32'h00500093);
        chk("fin_acc_addr", bus.mem_addr, 32'd0);
        wait_done("fin_acc", 32'd1);

        // start while a word is in flight drops it and restarts at word 0.
        start = 1'b1; tick(); start = 1'b0;
        drive(vt[1]); tick();
        bus.req_valid = 1'b0; start = 1'b1;
        #1 chk("restart_drop_we", 32'(bus.mem_we), 32'd0);
        tick(); start = 1'b0;
        chk("restart_count", 32'(count), 32'd0);
        drive(vt[0]); tick(); bus.req_valid = 1'b0;
        chk("restart_we", 32'(bus.mem_we), 32'd1);
        chk("restart_addr", bus.mem_addr, 32'd0);
        tick();
        chk("restart_count1", 32'(count), 32'd1);

        // start wins over finish in the same cycle: session stays in LOAD.
        start = 1'b1; finish = 1'b1; tick(); start = 1'b0; finish = 1'b0;
        chk("sf_count", 32'(count), 32'd0);
        drive(vt[2]);
        #1 chk("sf_ready", 32'(bus.req_ready), 32'd1);
        tick(); bus.req_valid = 1'b0;
        chk("sf_we", 32'(bus.mem_we), 32'd1);
        chk("sf_wdata", bus.mem_wdata, 32'h402081B3);
        chk("sf_addr", bus.mem_addr, 32'd0);
        finish = 1'b1; tick(); finish = 1'b0;
        wait_done("sf", 32'd1);

        // Reset mid-session: pending strobe suppressed, everything back to reset values.
        start = 1'b1; tick(); start = 1'b0;
        drive(vt[0]); tick();
        drive(vt[11]); tick();
        drive(vt[3]); tick();
        chk("pre_rst_err", 32'(err), 32'd1);
        bus.req_valid = 1'b0; rst = 1'b1;
        #1 chk("rst_we", 32'(bus.mem_we), 32'd0);
        tick();
        chk_reset("midrst");
        rst = 1'b0;
        tick();

        // Capacity 4: five-plus requests yield exactly four writes, then overflow.
        s_start = 1'b1; tick(); s_start = 1'b0;
        sbus.req_valid = 1'b1;
        nw = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (sbus.mem_we) begin
                chk($sformatf("ovf_addr%0d", nw), sbus.mem_addr, 32'(nw * 4));
                nw++;
            end
        end
        chk("ovf_writes", 32'(nw), 32'd4);
        chk("ovf_ready", 32'(sbus.req_ready), 32'd0);
        chk("ovf_err", 32'(s_err), 32'd1);
        chk("ovf_count", 32'(s_count), 32'd4);
        chk("ovf_busy", 32'(s_busy), 32'd1);
        sbus.req_valid = 1'b0;
        s_finish = 1'b1; tick(); s_finish = 1'b0;
        nw = 0;
        for (int k = 0; k < 10; k++) begin
            if (s_done) begin
                nw = 1;
                break;
            end
            tick();
        end
        chk("ovf_done_seen", 32'(nw), 32'd1);
        chk("ovf_done_count", 32'(s_count), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
